// File: rtl/rp_dac_delay.sv
// ============================================================================
// Module   : rp_dac_delay
// Purpose  : Trigger-aligned delay for ASG samples headed to the DAC, with a
//            settle window that masks samples while the tap changes.
// Options  : RP_DAC_DLY_MIDSCALE_EN - drive data to 0 during settle
// Revision : 1.0
// ============================================================================
`default_nettype none

module rp_dac_delay #(
    parameter int DW   = 14,
    parameter int DLYW = 4
) (
    input  logic            adc_clk_i,
    input  logic            adc_rstn_i,
    input  logic [DW-1:0]   dac_dat_i,
    input  logic            dac_val_i,
    input  logic [3:0]      set_trg_src_i,
    input  logic            set_trg_new_i,
    input  logic [DLYW-1:0] set_dly_i,
    input  logic            set_dly_we_i,
    output logic [DW-1:0]   dac_dat_o,
    output logic            dac_val_o,
    output logic [DLYW-1:0] dly_cur_o,
    output logic            busy_o
);

    localparam int MAXD = 2**DLYW;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    localparam logic [DLYW:0] CNT_ONE = {{DLYW{1'b0}}, 1'b1};

    logic [DW-1:0]   line_dat_q [MAXD];
    logic [DW-1:0]   line_dat_d [MAXD];
    logic [MAXD-1:0] line_val_q, line_val_d;

    logic [3:0]      last_src_q, last_src_d;
    logic [DLYW-1:0] user_dly_q, user_dly_d;
    logic [1:0]      prev_base_q, prev_base_d;
    logic [DLYW-1:0] dly_tgt_q, dly_tgt_d;
    logic [DLYW-1:0] dly_cur_q, dly_cur_d;
    logic [DLYW:0]   cnt_q, cnt_d;
    logic [0:0]      state_q, state_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            val_q, val_d;

    logic [1:0]      base_sel;
    logic [DLYW:0]   dly_sum;

    // Delay line: shifts unconditionally so taps stay time-coherent across settles
    always_comb begin
        line_dat_d    = line_dat_q;
        line_val_d    = {line_val_q[MAXD-2:0], dac_val_i};
        line_dat_d[0] = dac_dat_i;
        for (int i = 1; i < MAXD; i++) begin
            line_dat_d[i] = line_dat_q[i-1];
        end
    end

    always_comb begin
        last_src_d = set_trg_new_i ? set_trg_src_i : last_src_q;
        user_dly_d = set_dly_we_i  ? set_dly_i     : user_dly_q;
    end

    // Manual codes carry no timing of their own, so they reuse the last known base
    always_comb begin
        base_sel = prev_base_q;
        case (last_src_q)
            4'd2, 4'd3, 4'd4, 4'd5,
            4'd10, 4'd11, 4'd12, 4'd13: base_sel = 2'd1;
            4'd6, 4'd7, 4'd8, 4'd9:     base_sel = 2'd2;
            default:                    base_sel = prev_base_q;
        endcase
        prev_base_d = base_sel;
    end

    always_comb begin
        dly_sum   = {{(DLYW-1){1'b0}}, base_sel} + {1'b0, user_dly_q};
        dly_tgt_d = dly_sum[DLYW] ? {DLYW{1'b1}} : dly_sum[DLYW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        dly_cur_d = dly_cur_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dly_tgt_q != dly_cur_q) begin
                    dly_cur_d = dly_tgt_q;
                    cnt_d     = {1'b0, dly_tgt_q} + CNT_ONE;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A new target restarts the window instead of ending it
                if (dly_tgt_q != dly_cur_q) begin
                    dly_cur_d = dly_tgt_q;
                    cnt_d     = {1'b0, dly_tgt_q} + CNT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output sees the next state so masking lines up with busy_o
    always_comb begin
        if (state_d == ST_RUN) begin
            val_d = line_val_q[dly_cur_d];
            dat_d = line_dat_q[dly_cur_d];
        end else begin
            val_d = 1'b0;
`ifdef RP_DAC_DLY_MIDSCALE_EN
            dat_d = '0;
`else
            dat_d = dat_q;
`endif
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            line_dat_q  <= '{default: '0};
            line_val_q  <= '0;
            last_src_q  <= '0;
            user_dly_q  <= '0;
            prev_base_q <= '0;
            dly_tgt_q   <= '0;
            dly_cur_q   <= '0;
            cnt_q       <= '0;
            state_q     <= ST_RUN;
            dat_q       <= '0;
            val_q       <= 1'b0;
        end else begin
            line_dat_q  <= line_dat_d;
            line_val_q  <= line_val_d;
            last_src_q  <= last_src_d;
            user_dly_q  <= user_dly_d;
            prev_base_q <= prev_base_d;
            dly_tgt_q   <= dly_tgt_d;
            dly_cur_q   <= dly_cur_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            dat_q       <= dat_d;
            val_q       <= val_d;
        end
    end

    assign dac_dat_o = dat_q;
    assign dac_val_o = val_q;
    assign dly_cur_o = dly_cur_q;
    assign busy_o    = (state_q == ST_SETTLE);

endmodule

`default_nettype wire

// File: tb/tb_rp_dac_delay.sv
// ============================================================================
// Module   : tb_rp_dac_delay
// Purpose  : Self-checking bench for rp_dac_delay (directed + random stimulus)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rp_dac_delay;

    localparam int DW   = 14;
    localparam int DLYW = 4;
    localparam int MAXD = 16;
    localparam int HN   = 8192;

    logic            clk = 1'b0;
    logic            rstn;
    logic [DW-1:0]   din;
    logic            vin;
    logic [3:0]      src;
    logic            snew;
    logic [DLYW-1:0] dly;
    logic            dwe;
    logic [DW-1:0]   dac_dat_o;
    logic            dac_val_o;
    logic [DLYW-1:0] dly_cur_o;
    logic            busy_o;

    always #5 clk = ~clk;

    rp_dac_delay #(.DW(DW), .DLYW(DLYW)) dut (
        .adc_clk_i    (clk),
        .adc_rstn_i   (rstn),
        .dac_dat_i    (din),
        .dac_val_i    (vin),
        .set_trg_src_i(src),
        .set_trg_new_i(snew),
        .set_dly_i    (dly),
        .set_dly_we_i (dwe),
        .dac_dat_o    (dac_dat_o),
        .dac_val_o    (dac_val_o),
        .dly_cur_o    (dly_cur_o),
        .busy_o       (busy_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Base offset implied by a trigger source; -1 means "keep the previous base"
    function automatic int src_base(input int s);
        if ((s >= 2 && s <= 5) || (s >= 10 && s <= 13)) return 1;
        if (s >= 6 && s <= 9) return 2;
        return -1;
    endfunction

    // Reference model: input history plus the settings visible in each cycle
    logic [DW-1:0] hd [HN];
    logic          hv [HN];
    int            cyc = 0;
    int            valid_from = 0;
    int            m_src = 0, m_usr = 0, m_pbase = 0, m_tgt = 0, m_cur = 0;
    int            settle_end = 0;
    logic [DW-1:0] m_hold = '0;

    always @(negedge clk) begin : p_cmp
        int            idx, b, nt;
        bit            busy;
        logic          ev;
        logic [DW-1:0] ed;
        if (!rstn) begin
            chk("rst_dat", 32'(dac_dat_o), 0);
            chk("rst_val", 32'(dac_val_o), 0);
            chk("rst_cur", 32'(dly_cur_o), 0);
            chk("rst_busy", 32'(busy_o), 0);
            m_src = 0; m_usr = 0; m_pbase = 0; m_tgt = 0; m_cur = 0;
            settle_end = 0; m_hold = '0;
            valid_from = cyc + 1;
        end else begin
            busy = (cyc < settle_end);
            idx  = cyc - 2 - m_cur;
            if (busy) begin
                ev = 1'b0;
`ifdef RP_DAC_DLY_MIDSCALE_EN
                ed = '0;
`else
                ed = m_hold;
`endif
            end else if (idx < valid_from) begin
                ev = 1'b0;
                ed = '0;
            end else begin
                ev = hv[idx % HN];
                ed = hd[idx % HN];
            end
            if (!busy) m_hold = ed;
            chk("dat", 32'(dac_dat_o), 32'(ed));
            chk("val", 32'(dac_val_o), 32'(ev));
            chk("cur", 32'(dly_cur_o), m_cur);
            chk("busy", 32'(busy_o), busy ? 1 : 0);

            hd[cyc % HN] = din;
            hv[cyc % HN] = vin;

            b = src_base(m_src);
            if (b < 0) b = m_pbase;
            else m_pbase = b;
            nt = b + m_usr;
            if (nt > MAXD - 1) nt = MAXD - 1;
            // Tap change: settle covers tgt+1 cycles starting next cycle
            if (m_tgt != m_cur) begin
                m_cur      = m_tgt;
                settle_end = cyc + 2 + m_tgt;
            end
            m_tgt = nt;
            if (snew) m_src = int'(src);
            if (dwe)  m_usr = int'(dly);
        end
        cyc++;
    end

    int unsigned ramp = 0;
    int unsigned vn;

    task automatic drv(input int s, input bit n, input int d, input bit w);
        din  = DW'(ramp);
        vin  = 1'b1;
        vn   = ramp;
        ramp = ramp + 1;
        src  = 4'(s);
        snew = n;
        dly  = DLYW'(d);
        dwe  = w;
    endtask

    task automatic tick(input int s, input bit n, input int d, input bit w);
        @(posedge clk);
        #2;
        drv(s, n, d, w);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(0, 1'b0, 0, 1'b0);
    endtask

    int unsigned v0;

    initial begin
        rstn = 1'b0;
        din = '0; vin = 1'b0; src = '0; snew = 1'b0; dly = '0; dwe = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        drv(0, 1'b0, 0, 1'b0);
        v0 = vn;
        idle(6);
        chk("lit_lag2_dat", 32'(dac_dat_o), v0 + 4);
        chk("lit_lag2_cur", 32'(dly_cur_o), 0);

        // Level source -> base 1
        tick(4, 1'b1, 0, 1'b0);
        v0 = vn;
        idle(2);
        chk("lit_pre_busy", 32'(busy_o), 0);
        idle(1);
        chk("lit_src4_busy", 32'(busy_o), 1);
        chk("lit_src4_cur", 32'(dly_cur_o), 1);
        chk("lit_src4_val", 32'(dac_val_o), 0);
`ifdef RP_DAC_DLY_MIDSCALE_EN
        chk("lit_src4_hold", 32'(dac_dat_o), 0);
`else
        chk("lit_src4_hold", 32'(dac_dat_o), v0);
`endif
        idle(2);
        chk("lit_src4_val2", 32'(dac_val_o), 1);
        chk("lit_src4_lag3", 32'(dac_dat_o), v0 + 2);

        // Ext source plus max user delay -> saturated tap 15
        idle(4);
        tick(7, 1'b1, 15, 1'b1);
        v0 = vn;
        idle(3);
        chk("lit_sat_cur", 32'(dly_cur_o), 15);
        idle(15);
        chk("lit_sat_busy_end", 32'(busy_o), 1);
        idle(1);
        chk("lit_sat_busy_off", 32'(busy_o), 0);
        chk("lit_sat_dat0", 32'(dac_dat_o), v0 + 2);
        idle(1);
        chk("lit_sat_dat1", 32'(dac_dat_o), v0 + 3);

        // Manual source keeps the previous base: no settle
        tick(6, 1'b1, 1, 1'b1);
        idle(10);
        tick(0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("lit_manual_busy", 32'(busy_o), 0);
        end
        chk("lit_manual_cur", 32'(dly_cur_o), 3);

        // Retarget during settle -> one continuous busy window
        tick(0, 1'b0, 0, 1'b1);
        idle(8);
        tick(0, 1'b0, 1, 1'b1);
        idle(3);
        chk("lit_rt_cur3", 32'(dly_cur_o), 3);
        tick(0, 1'b0, 3, 1'b1);
        idle(2);
        chk("lit_rt_busy6", 32'(busy_o), 1);
        idle(1);
        chk("lit_rt_cur5", 32'(dly_cur_o), 5);
        chk("lit_rt_busy7", 32'(busy_o), 1);
        idle(5);
        chk("lit_rt_busy12", 32'(busy_o), 1);
        idle(1);
        chk("lit_rt_busy13", 32'(busy_o), 0);

        // Asynchronous reset in the middle of a settle
        tick(0, 1'b0, 0, 1'b1);
        idle(4);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        drv(0, 1'b0, 0, 1'b0);
        #1;
        chk("lit_arst_dat", 32'(dac_dat_o), 0);
        chk("lit_arst_val", 32'(dac_val_o), 0);
        chk("lit_arst_cur", 32'(dly_cur_o), 0);
        chk("lit_arst_busy", 32'(busy_o), 0);
        idle(2);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        drv(0, 1'b0, 0, 1'b0);
        v0 = vn;
        idle(2);
        chk("lit_rel_dat", 32'(dac_dat_o), v0);
        chk("lit_rel_val", 32'(dac_val_o), 1);
        chk("lit_rel_cur", 32'(dly_cur_o), 0);

        // Random traffic, strobes and occasional resets
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #2;
            rstn = ($urandom_range(0, 599) != 0);
            din  = DW'($urandom);
            vin  = 1'($urandom);
            src  = 4'($urandom_range(0, 15));
            snew = ($urandom_range(0, 39) == 0);
            dly  = DLYW'($urandom_range(0, 15));
            dwe  = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk);
        #2;
        rstn = 1'b1; snew = 1'b0; dwe = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rp_dac_delay.md
Name: rp_dac_delay

Overview:
Transmit-side counterpart of the ADC trigger-alignment delay. Delays generator (ASG) samples headed for the DAC so they line up with the trigger path. The delay is a trigger-source-dependent base plus a programmable user offset. Sits between the ASG sample output and the DAC output register. A settle FSM masks invalid samples whenever the tap changes.

Parameters:
DW, 14, sample data width
DLYW, 4, delay select width; delay line depth MAXD = 2**DLYW (taps 0..MAXD-1)

Ports:
adc_clk_i  input  1  ADC/DAC clock; the only clock
adc_rstn_i  input  1  reset, asynchronous, active low
dac_dat_i  input  DW  ASG sample
dac_val_i  input  1  sample valid
set_trg_src_i  input  4  trigger source code
set_trg_new_i  input  1  strobe: latch set_trg_src_i
set_dly_i  input  DLYW  user delay offset
set_dly_we_i  input  1  strobe: latch set_dly_i
dac_dat_o  output  DW  delayed sample
dac_val_o  output  1  delayed valid, masked during settle
dly_cur_o  output  DLYW  tap currently in use
busy_o  output  1  high while in SETTLE

Behaviour:
- Reset (async assert, sync release): dac_dat_o=0, dac_val_o=0, dly_cur_o=0, busy_o=0, state RUN, last_src=0, prev_base=0, user_dly=0, dly_tgt=0, cnt=0, delay line data and valid cleared.
- Delay line: MAXD-entry shift register of {val,data}. Shifts every clock, including during SETTLE. line[0] <= input.
- Output register: {dac_val_o,dac_dat_o} <= line[dly_cur] in RUN. Sample at input cycle t appears at output cycle t+2+dly_cur.
- last_src <= set_trg_src_i on set_trg_new_i. user_dly <= set_dly_i on set_dly_we_i. Both strobes in the same cycle: both apply.
- Base decode from last_src:
  - 2,3,4,5,10,11,12,13 (level) -> 1
  - 6,7,8,9 (external/ASG) -> 2
  - any other (manual) -> prev_base
  - prev_base updates whenever a level or ext/ASG code decodes.
- dly_tgt registered = min(base + user_dly, MAXD-1). Use a DLYW+1-bit sum, saturate, no wrap.
- FSM:
  - RUN: if dly_tgt != dly_cur -> dly_cur<=dly_tgt, cnt<=dly_tgt+1, go SETTLE. Else stay.
  - SETTLE: dac_val_o=0, dac_dat_o holds last RUN value. cnt decrements each cycle. At cnt==1 go RUN; first RUN output comes the following cycle.
  - SETTLE and dly_tgt != dly_cur: restart, dly_cur<=dly_tgt, cnt<=dly_tgt+1.
- Strobe latency: strobe at cycle n -> last_src/user_dly at n+1 -> dly_tgt at n+2 -> dly_cur_o/busy_o change at n+3.
- Strobe that yields an unchanged target: no SETTLE, no output glitch.
- Reset mid-SETTLE: immediate return to reset values.

Optional Feature:
RP_DAC_DLY_MIDSCALE_EN:
- Defined: during SETTLE, dac_dat_o is forced to 0 (signed midscale) instead of holding the last value.
- Undefined: hold-last behaviour as above.
- dac_val_o masking is identical in both builds.

Test Plan:
- Reset, then ramp dac_dat_i=0,1,2…, val=1, no strobes -> dac_dat_o lags input by 2 cycles, dly_cur_o=0.
- set_trg_src_i=4, set_trg_new_i pulse at n -> busy_o=1 and dly_cur_o=1 at n+3. dac_val_o=0 for 2 cycles, then the ramp resumes with 3-cycle lag.
- src=7, set_dly_i=15 (DLYW=4) -> dly_tgt saturates to 15, settle 16 cycles, then 17-cycle lag with no skipped or duplicated ramp values.
- After src=6, strobe src=0 (manual) -> base stays 2, no SETTLE, busy_o stays 0.
- During SETTLE (target 3), write set_dly_i to give target 5 -> counter restarts at 6, dly_cur_o=5, single continuous busy_o window.
- Assert adc_rstn_i=0 mid-SETTLE -> all outputs 0 immediately. After release, 2-cycle lag with dly_cur_o=0. With RP_DAC_DLY_MIDSCALE_EN, dac_dat_o=0 throughout SETTLE.
